// File: rtl/controller_arbiter_if.sv
// ============================================================================
// controller_arbiter_if : source words, route select and routed player words
// Rev 1.0
// ============================================================================
`default_nettype none

interface controller_arbiter_if;
  logic [11:0] b_board_in;
  logic [11:0] N64_in;
  logic [11:0] remote_in;
  logic [3:0]  select_in;
  logic [11:0] NES0;
  logic [11:0] NES1;
  logic [11:0] SNES0;
  logic [11:0] SNES1;
  logic [1:0]  owner;
  logic        owner_valid;

  modport master (
    output b_board_in, N64_in, remote_in, select_in,
    input  NES0, NES1, SNES0, SNES1, owner, owner_valid
  );

  modport slave (
    input  b_board_in, N64_in, remote_in, select_in,
    output NES0, NES1, SNES0, SNES1, owner, owner_valid
  );
endinterface

`default_nettype wire

// File: rtl/controller_arbiter.sv
// ============================================================================
// controller_arbiter : sticky-ownership arbiter routing one of three button
//                      sources to a selected NES/SNES player word
// Rev 1.0
// ============================================================================
`default_nettype none

module controller_arbiter #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset_in,
  controller_arbiter_if.slave  bus
);

  localparam int              CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_BB  = 2'd1,
    OWN_N64 = 2'd2,
    OWN_REM = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      bb_q, bb_d, n64_q, n64_d, rem_q, rem_d;
  logic [3:0]       sel_q, sel_d;
  logic [11:0]      nes0_q, nes0_d, nes1_q, nes1_d;
  logic [11:0]      snes0_q, snes0_d, snes1_q, snes1_d;
  logic [11:0]      word;
  logic             bb_act, n64_act, rem_act, own_act;

  assign bb_act  = |bb_q;
  assign n64_act = |n64_q;
  assign rem_act = |rem_q;

  always_comb begin
    bb_d  = bus.b_board_in;
    n64_d = bus.N64_in;
    rem_d = bus.remote_in;
    sel_d = bus.select_in;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_act = 1'b0;
    case (state_q)
      IDLE: begin
        if (bb_act) begin
          state_d = OWN_BB;
          cnt_d   = HOLD_LOAD;
        end else if (n64_act) begin
          state_d = OWN_N64;
          cnt_d   = HOLD_LOAD;
        end else if (rem_act) begin
          state_d = OWN_REM;
          cnt_d   = HOLD_LOAD;
        end
      end
      default: begin
        case (state_q)
          OWN_BB:  own_act = bb_act;
          OWN_N64: own_act = n64_act;
          default: own_act = rem_act;
        endcase
        // Only the owner's activity matters; other sources wait for IDLE.
        if (own_act) begin
          cnt_d = HOLD_LOAD;
        end else if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Word follows the next-state owner so data and ownership change together.
  always_comb begin
    word    = 12'h000;
    nes0_d  = 12'h000;
    nes1_d  = 12'h000;
    snes0_d = 12'h000;
    snes1_d = 12'h000;
    case (state_d)
      OWN_BB:  word = bb_q;
      OWN_N64: word = n64_q;
      OWN_REM: word = rem_q;
      default: word = 12'h000;
    endcase
    if (sel_q[3:2] == 2'b00) begin
      case (sel_q[1:0])
        2'd0:    nes0_d  = {4'h0, word[7:0]};
        2'd1:    nes1_d  = {4'h0, word[7:0]};
        2'd2:    snes0_d = word;
        default: snes1_d = word;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bb_q    <= 12'h000;
      n64_q   <= 12'h000;
      rem_q   <= 12'h000;
      sel_q   <= 4'h0;
      nes0_q  <= 12'h000;
      nes1_q  <= 12'h000;
      snes0_q <= 12'h000;
      snes1_q <= 12'h000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bb_q    <= bb_d;
      n64_q   <= n64_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      nes0_q  <= nes0_d;
      nes1_q  <= nes1_d;
      snes0_q <= snes0_d;
      snes1_q <= snes1_d;
    end
  end

  assign bus.owner       = 2'(state_q);
  assign bus.owner_valid = (state_q != IDLE);
  assign bus.NES0        = nes0_q;
  assign bus.NES1        = nes1_q;
  assign bus.SNES0       = snes0_q;
  assign bus.SNES1       = snes1_q;

endmodule

`default_nettype wire

// File: doc/controller_arbiter.md
CONTROLLER_ARBITER -- requirements
Module: controller_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000: idle cycles before ownership is released; SHALL be >= 1.
REQ-002 clk  input  1  single clock for all state.
REQ-003 reset_in  input  1  reset, asynchronous assert, active-low.
REQ-004 b_board_in  input  12  button-board word, active-high buttons; bit map: 0 up, 1 down, 2 left, 3 right, 4 start, 5 sel, 6 A, 7 B, 8 X, 9 Y, 10 L, 11 R.
REQ-005 N64_in  input  12  N64 receiver word, same bit map.
REQ-006 remote_in  input  12  remote receiver word, same bit map.
REQ-007 select_in  input  4  game/route select.
REQ-008 NES0, NES1  output  12 each  NES player 0/1 words.
REQ-009 SNES0, SNES1  output  12 each  SNES player 0/1 words.
REQ-010 owner  output  2  current owner: 0 none, 1 button board, 2 N64, 3 remote.
REQ-011 owner_valid  output  1  high when owner != 0.

Function
REQ-012 Stage 1: all three source words and select_in SHALL be registered each clk edge (s1 copies); no other logic reads the raw inputs.
REQ-013 A source is active when its s1 word is nonzero.
REQ-014 FSM states IDLE, OWN_BB, OWN_N64, OWN_REM; owner output SHALL encode the state per REQ-010, registered.
REQ-015 IDLE: if any source active, go to its OWN state; simultaneous activity priority is button board > N64 > remote; else stay IDLE.
REQ-016 On entering an OWN state, idle counter SHALL load HOLD_CYCLES.
REQ-017 OWN_x: owner active -> counter reloads HOLD_CYCLES; owner inactive and counter > 1 -> counter decrements; owner inactive and counter == 1 -> go to IDLE on that edge.
REQ-018 OWN_x: activity on non-owner sources SHALL be ignored; no preemption.
REQ-019 Release leaves IDLE for at least one cycle; re-arbitration happens on the following edge per REQ-015.
REQ-020 Counter width SHALL be $clog2(HOLD_CYCLES+1); no wrap: counter never decrements below 1.
REQ-021 Selected word = s1 word of the next-state owner; zero when next state is IDLE.
REQ-022 Routing by s1 select[1:0]: 0 -> NES0, 1 -> NES1, 2 -> SNES0, 3 -> SNES1; every non-selected output SHALL be 0.
REQ-023 If s1 select[3:2] != 0, all four word outputs SHALL be 0; FSM continues to run.
REQ-024 NES0/NES1 bits [11:8] SHALL always be 0; bits [7:0] carry the selected word.
REQ-025 All word outputs SHALL be registered; latency from a source input change (or select_in change) to word output is exactly 2 clk edges.
REQ-026 The owner transition and its first routed word SHALL appear on the same edge (no cycle with a new owner and stale data).
REQ-027 select_in change while owned SHALL reroute without affecting FSM state or counter.

Reset
REQ-028 reset_in low SHALL asynchronously force: state IDLE, owner 0, owner_valid 0, counter 0, all s1 registers 0, NES0/NES1/SNES0/SNES1 0.
REQ-029 Reset mid-ownership SHALL discard ownership; after release, first active source is arbitrated fresh from IDLE per REQ-015, earliest 2 edges after release.

Verification
REQ-030 Reset release, select 0, N64_in = 12'h010 at cycle 0 -> owner 2, NES0 = 12'h010 at edge 2; NES1/SNES0/SNES1 = 0.
REQ-031 IDLE, all three sources = 12'h001 same cycle -> owner 1 (button board) wins; then N64_in = 12'hFFF while board held -> outputs still 12'h001.
REQ-032 HOLD_CYCLES = 4, owner remote, remote_in -> 0 -> owner stays 3 for 4 edges after s1 goes zero, IDLE on 4th; with N64 pending, owner 2 one edge later.
REQ-033 select 2, board = 12'hC00 -> SNES0 = 12'hC00; select 0 -> NES0 = 12'h000 (bits 11:8 masked); select 4'h4 -> all outputs 0, owner unchanged.
REQ-034 Owner N64 held, reset_in pulsed low mid-cycle -> all outputs 0 immediately (asynchronous); after release N64 regains ownership at edge 2.
REQ-035 Owner active toggling every 3 cycles with HOLD_CYCLES = 4 -> no release ever; counter reload verified.
